cache_arbiter_rr: RTL and testbench

- Parametrised N-port successor to the two-port L1-to-L2 arbiter control.
- Sits between N_PORTS L1 requesters (I-cache, D-cache, prefetcher, ...) and a single L2 port. Read and write requests are arbitrated round-robin rather than by fixed priority.
- Integrates the address/data latches (MAR, MDR L1->L2, MDR L2->L1) with the control FSM.
- The L2 handshake is held until l2_resp. The response is returned to the winning port one cycle later, from a registered line.

---
 rtl/cache_arbiter_rr.sv | 112 +++++++++++
 tb/tb_cache_arbiter_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter_rr.sv
// cache_arbiter_rr: N-port round-robin L1-to-L2 line arbiter with integrated MAR/MDR latches
//   clk, rst                 : clock, synchronous active-high reset
//   port_read/port_write     : per-port level requests, held until port_resp
//   port_addr/port_wdata     : per-port address and write line, port i at [i*W +: W]
//   port_rdata/port_resp     : broadcast read line and one-hot completion pulse
//   l2_addr/l2_wdata         : registered address and write line towards L2
//   l2_read/l2_write/l2_resp : L2 strobes held until the L2 completion pulse
//   l2_rdata                 : L2 read line
//   busy/grant_id/arb_error  : status, current or last grant, sticky watchdog error
//   Optional ARB_TIMEOUT_EN  : L2 watchdog that forces completion after TIMEOUT_CYCLES
module cache_arbiter_rr #(
  parameter int N_PORTS        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [N_PORTS-1:0]                             port_read,
  input  logic [N_PORTS-1:0]                             port_write,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]                  port_addr,
  input  logic [N_PORTS*LINE_WIDTH-1:0]                  port_wdata,
  output logic [LINE_WIDTH-1:0]                          port_rdata,
  output logic [N_PORTS-1:0]                             port_resp,
  output logic [ADDR_WIDTH-1:0]                          l2_addr,
  output logic [LINE_WIDTH-1:0]                          l2_wdata,
  input  logic [LINE_WIDTH-1:0]                          l2_rdata,
  output logic                                           l2_read,
  output logic                                           l2_write,
  input  logic                                           l2_resp,
  output logic                                           busy,
  output logic [(N_PORTS > 1 ? $clog2(N_PORTS) : 1)-1:0] grant_id,
  output logic                                           arb_error
);
  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_last, r_grant, w_win, w_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata, r_rdata;
  logic [N_PORTS-1:0] w_req;
  logic r_is_write, w_found, w_timeout;
  assign w_req = port_read | port_write;
  // First requester at or after last grant + 1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_idx = GW'((int'(r_last) + 1 + k) % N_PORTS);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  // Counter is zero outside ISSUE, so it is already cleared on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == ISSUE) ? r_cnt + 1'b1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
  assign w_timeout = (r_state == ISSUE) && !l2_resp && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign arb_error = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
  assign arb_error = 1'b0;
`endif
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_found ? ISSUE : IDLE) :
             (r_state == ISSUE) ? ((l2_resp || w_timeout) ? RESP : ISSUE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= GW'(N_PORTS - 1);
      r_grant    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        r_addr     <= port_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata    <= port_wdata[w_win*LINE_WIDTH +: LINE_WIDTH];
        r_is_write <= port_write[w_win];
        r_grant    <= w_win;
        r_last     <= w_win;
      end
      if (r_state == ISSUE && l2_resp && !r_is_write) r_rdata <= l2_rdata;
    end
  end
  assign l2_read    = (r_state == ISSUE) && !r_is_write;
  assign l2_write   = (r_state == ISSUE) && r_is_write;
  assign port_resp  = (r_state == RESP) ? N_PORTS'(1) << r_grant : '0;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant;
  assign l2_addr    = r_addr;
  assign l2_wdata   = r_wdata;
  assign port_rdata = r_rdata;
endmodule

// File: tb/tb_cache_arbiter_rr.sv
// tb_cache_arbiter_rr: scoreboard bench for cache_arbiter_rr with four ports
module tb_cache_arbiter_rr;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] port_read = '0, port_write = '0, port_resp;
  logic [NP*AW-1:0] port_addr = '0;
  logic [NP*LW-1:0] port_wdata = '0;
  logic [LW-1:0] port_rdata, l2_wdata, l2_rdata = '0;
  logic [AW-1:0] l2_addr;
  logic l2_read, l2_write, l2_resp = 1'b0, busy, arb_error;
  logic [1:0] grant_id;
  cache_arbiter_rr #(.N_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .port_read(port_read), .port_write(port_write),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
    .port_resp(port_resp), .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_resp(l2_resp), .busy(busy),
    .grant_id(grant_id), .arb_error(arb_error)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [NP-1:0] resp; logic [LW-1:0] rdata;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  logic [LW-1:0] m_rdata = '0;
  logic [LW-1:0] a5 = {32{8'hA5}};
  int s_nrd, s_nwr;
  logic [NP-1:0] s_resp;
  logic [LW-1:0] s_rdat, s_wd;
  logic [AW-1:0] s_addr;
  logic [1:0] s_gid;
  logic s_busy_after;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Plays the L2 side of one transaction; records what it saw for the caller to judge.
  task automatic serve(input int lat, input logic [LW-1:0] rd, input bit keep);
    int w = 0;
    s_nrd = 0; s_nwr = 0; s_resp = '0; s_busy_after = 1'b1; s_gid = '0; s_addr = '0; s_wd = '0; s_rdat = '0;
    tick;
    while (!(l2_read || l2_write) && w < 20) begin tick; w++; end
    if (!(l2_read || l2_write)) return;
    s_addr = l2_addr; s_wd = l2_wdata; s_gid = grant_id;
    for (int c = 0; c < lat; c++) begin
      s_nrd += int'(l2_read);
      s_nwr += int'(l2_write);
      if (c < lat - 1) tick;
    end
    l2_resp = 1'b1; l2_rdata = rd;
    tick;
    l2_resp = 1'b0;
    s_resp = port_resp; s_rdat = port_rdata;
    s_nrd += int'(l2_read); s_nwr += int'(l2_write);
    if (!keep) begin port_read = '0; port_write = '0; end
    tick;
    s_busy_after = busy;
  endtask
  task automatic do_reset;
    port_read = '0; port_write = '0; l2_resp = 1'b0;
    rst = 1'b1; tick; tick; rst = 1'b0;
    m_rdata = '0;
  endtask
  task automatic test_reset;
    logic [9:0] obs;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      tick;
      obs = {l2_read, l2_write, port_resp, busy, arb_error, grant_id};
      n_cmp++;
      if (obs !== 10'd0 || l2_addr !== '0 || l2_wdata !== '0 || port_rdata !== '0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got ctl=%b addr=%h rdata=%h, need all zero", i, obs, l2_addr, port_rdata);
      end
    end
  endtask
  task automatic test_single_read;
    port_read = 4'b0010; port_addr[1*AW +: AW] = 32'h0000_1040;
    q.push_back('{resp: 4'b0010, rdata: a5}); m_rdata = a5;
    serve(3, a5, 0);
    e = q.pop_front();
    n_cmp++; if (s_addr !== 32'h0000_1040) begin n_err++; $display("FAIL rd_addr: got %h need 00001040", s_addr); end
    n_cmp++; if (s_nrd !== 3 || s_nwr !== 0) begin n_err++; $display("FAIL rd_strobe: got rd=%0d wr=%0d need rd=3 wr=0", s_nrd, s_nwr); end
    n_cmp++; if (s_resp !== e.resp) begin n_err++; $display("FAIL rd_resp: got %b need %b", s_resp, e.resp); end
    n_cmp++; if (s_rdat !== e.rdata) begin n_err++; $display("FAIL rd_data: got %h need %h", s_rdat, e.rdata); end
    n_cmp++; if (s_busy_after !== 1'b0) begin n_err++; $display("FAIL rd_idle: got busy %b need 0", s_busy_after); end
  endtask
  task automatic test_single_write;
    port_write = 4'b0001; port_addr[0 +: AW] = 32'h0000_2000; port_wdata[0 +: LW] = 256'h1234;
    q.push_back('{resp: 4'b0001, rdata: m_rdata});
    serve(2, {32{8'h5A}}, 0);
    e = q.pop_front();
    n_cmp++; if (s_wd !== 256'h1234 || s_addr !== 32'h0000_2000) begin n_err++; $display("FAIL wr_latch: got addr %h data %h need 00002000 1234", s_addr, s_wd); end
    n_cmp++; if (s_nwr !== 2 || s_nrd !== 0) begin n_err++; $display("FAIL wr_strobe: got wr=%0d rd=%0d need wr=2 rd=0", s_nwr, s_nrd); end
    n_cmp++; if (s_resp !== e.resp) begin n_err++; $display("FAIL wr_resp: got %b need %b", s_resp, e.resp); end
    n_cmp++; if (s_rdat !== e.rdata) begin n_err++; $display("FAIL wr_rdata_kept: got %h need %h", s_rdat, e.rdata); end
  endtask
  task automatic test_rw_same_port;
    port_read = 4'b0100; port_write = 4'b0100; port_wdata[2*LW +: LW] = 256'hBEEF;
    q.push_back('{resp: 4'b0100, rdata: m_rdata});
    serve(3, '1, 0);
    e = q.pop_front();
    n_cmp++; if (s_nwr !== 3 || s_nrd !== 0) begin n_err++; $display("FAIL rw_is_write: got wr=%0d rd=%0d need wr=3 rd=0", s_nwr, s_nrd); end
    n_cmp++; if (s_resp !== e.resp || s_rdat !== e.rdata) begin n_err++; $display("FAIL rw_resp: got %b/%h need %b/%h", s_resp, s_rdat, e.resp, e.rdata); end
    n_cmp++; if (s_wd !== 256'hBEEF) begin n_err++; $display("FAIL rw_wdata: got %h need beef", s_wd); end
  endtask
  task automatic test_round_robin;
    logic [LW-1:0] rd;
    int p;
    do_reset;
    for (int i = 0; i < NP; i++) port_addr[i*AW +: AW] = 32'h0000_4000 + 32'(i * 64);
    port_read = '1;
    for (int i = 0; i < 5; i++) begin
      p = i % NP;
      rd = LW'(32'hC0DE_0000 + 32'(i));
      q.push_back('{resp: NP'(1) << p, rdata: rd});
      serve(1, rd, 1);
      e = q.pop_front();
      n_cmp++; if (s_gid !== 2'(p) || s_resp !== e.resp) begin n_err++; $display("FAIL rr_order %0d: got gid %0d resp %b need %0d %b", i, s_gid, s_resp, p, e.resp); end
      n_cmp++; if (s_rdat !== e.rdata || s_addr !== 32'h0000_4000 + 32'(p * 64)) begin n_err++; $display("FAIL rr_data %0d: got %h @%h need %h", i, s_rdat, s_addr, e.rdata); end
      n_cmp++; if (s_busy_after !== 1'b0) begin n_err++; $display("FAIL rr_idle_gap %0d: got busy %b need 0", i, s_busy_after); end
      m_rdata = rd;
    end
    port_read = '0;
    tick; tick;
  endtask
  task automatic test_reset_mid;
    logic [LW-1:0] rd = LW'(32'h7777_0001);
    port_read = 4'b0010; port_addr[1*AW +: AW] = 32'h0000_3000;
    tick;
    n_cmp++; if (l2_read !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("FAIL rm_issue: got rd %b gid %0d need 1 1", l2_read, grant_id); end
    tick;
    rst = 1'b1;
    tick;
    n_cmp++; if ({l2_read, l2_write, busy, port_resp} !== 7'd0) begin n_err++; $display("FAIL rm_drop: got %b need 0", {l2_read, l2_write, busy, port_resp}); end
    rst = 1'b0; m_rdata = '0;
    port_read = 4'b0101;
    q.push_back('{resp: 4'b0001, rdata: rd});
    serve(1, rd, 0);
    e = q.pop_front();
    n_cmp++; if (s_gid !== 2'd0 || s_resp !== e.resp || s_rdat !== e.rdata) begin n_err++; $display("FAIL rm_next_grant: got gid %0d resp %b need 0 %b", s_gid, s_resp, e.resp); end
    m_rdata = rd;
  endtask
  task automatic test_idle_resp;
    l2_resp = 1'b1; l2_rdata = {8{32'hDEAD_BEEF}};
    tick;
    l2_resp = 1'b0;
    tick;
    n_cmp++; if ({busy, port_resp} !== 5'd0 || port_rdata !== m_rdata) begin n_err++; $display("FAIL idle_l2_resp: got %b %h need 0 %h", {busy, port_resp}, port_rdata, m_rdata); end
  endtask
  task automatic test_timeout;
    int hi = 0, nresp = 0;
    logic [NP-1:0] r = '0;
    port_read = 4'b1000; port_addr[3*AW +: AW] = 32'h0000_5000;
`ifdef ARB_TIMEOUT_EN
    q.push_back('{resp: 4'b1000, rdata: m_rdata});
    for (int i = 0; i < 40; i++) begin
      tick;
      if (port_resp != '0) begin r = port_resp; break; end
      hi += int'(l2_read);
    end
    e = q.pop_front();
    port_read = '0;
    n_cmp++; if (hi !== 8 || r !== e.resp) begin n_err++; $display("FAIL to_fire: got %0d cycles resp %b need 8 %b", hi, r, e.resp); end
    n_cmp++; if (arb_error !== 1'b1 || port_rdata !== e.rdata) begin n_err++; $display("FAIL to_error: got err %b rdata %h need 1 %h", arb_error, port_rdata, e.rdata); end
    tick;
    n_cmp++; if (port_resp !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL to_once: got resp %b busy %b need 0 0", port_resp, busy); end
`else
    for (int i = 0; i < 30; i++) begin
      tick;
      hi += int'(l2_read && busy);
      nresp += int'(port_resp != '0);
    end
    n_cmp++; if (hi !== 30 || nresp !== 0 || arb_error !== 1'b0) begin n_err++; $display("FAIL no_timeout: got hold %0d resp %0d err %b need 30 0 0", hi, nresp, arb_error); end
    q.push_back('{resp: 4'b1000, rdata: a5});
    serve(1, a5, 0);
    e = q.pop_front();
    n_cmp++; if (s_resp !== e.resp || s_rdat !== e.rdata) begin n_err++; $display("FAIL late_resp: got %b %h need %b %h", s_resp, s_rdat, e.resp, e.rdata); end
    m_rdata = a5;
    if (r !== '0) n_err++;
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_rw_same_port;
    test_round_robin;
    test_reset_mid;
    test_idle_resp;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
